// File: rtl/fir_pkg.sv
// Shared parameters, FSM state type and arithmetic helpers for the stereo FIR MAC sequencer.
package fir_pkg;

    localparam int unsigned TAPS      = 9;
    localparam int unsigned DW        = 16;
    localparam int unsigned CW        = 16;
    localparam int unsigned ACCW      = 40;
    localparam int unsigned COEF_FRAC = 15;
    localparam int unsigned PW        = DW + CW;
    localparam int unsigned AW        = 4;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC_L = 2'd1,
        MAC_R = 2'd2,
        OUT   = 2'd3
    } state_e;

    // (newest - k) mod TAPS without a divider; both operands are always < TAPS
    function automatic logic [AW-1:0] circ_idx(input logic [AW-1:0] newest,
                                               input logic [AW-1:0] k);
        if (newest >= k) begin
            return newest - k;
        end
        return newest - k + AW'(TAPS);
    endfunction

    function automatic logic [DW-1:0] sat_q15(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] shr;
        shr = acc >>> COEF_FRAC;
        if (shr > ACCW'(SAT_MAX)) begin
            return DW'(SAT_MAX);
        end
        if (shr < ACCW'(SAT_MIN)) begin
            return DW'(SAT_MIN);
        end
        return DW'(shr);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed 16x16 multiply-accumulate with clear/enable and a saturating Q1.15 output stage.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] coef,
    input  logic [DW-1:0] sample,
    output logic [DW-1:0] sat_c
);

    logic signed [PW-1:0]   prod_c;
    logic signed [ACCW-1:0] sum_c;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    // sat_c reflects the sum including the current product, so the last tap can be captured
    // in the same cycle that clears the accumulator
    always_comb begin
        prod_c = PW'($signed(coef)) * PW'($signed(sample));
        sum_c  = acc_q + ACCW'(prod_c);
        acc_d  = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_c;
        end
        sat_c = sat_q15(sum_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed stereo 9-tap FIR controller: circular sample history, double-buffered
// coefficient bank and one shared MAC stepped by a two-process FSM per codec frame.
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          AUD_DACLRCK,
    input  logic [31:0]   audioIn,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic [31:0]   audioOut,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    state_e        state_q, state_d;
    logic          lrck_q;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] newest_q, newest_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] buf_l_q [0:TAPS-1];
    logic [DW-1:0] buf_l_d [0:TAPS-1];
    logic [DW-1:0] buf_r_q [0:TAPS-1];
    logic [DW-1:0] buf_r_d [0:TAPS-1];
    logic [CW-1:0] work_q  [0:TAPS-1];
    logic [CW-1:0] work_d  [0:TAPS-1];
    logic [CW-1:0] act_q   [0:TAPS-1];
    logic [CW-1:0] act_d   [0:TAPS-1];
    logic [DW-1:0] left_q, left_d;
    logic [DW-1:0] right_q, right_d;
    logic [31:0]   audio_out_q, audio_out_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;

    logic          edge_c;
    logic [AW-1:0] idx_c;
    logic          mac_clr_c;
    logic          mac_en_c;
    logic [CW-1:0] mac_coef_c;
    logic [DW-1:0] mac_sample_c;
    logic [DW-1:0] mac_sat_c;

    fir_mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (mac_clr_c),
        .en     (mac_en_c),
        .coef   (mac_coef_c),
        .sample (mac_sample_c),
        .sat_c  (mac_sat_c)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        newest_d    = newest_q;
        wr_ptr_d    = wr_ptr_q;
        buf_l_d     = buf_l_q;
        buf_r_d     = buf_r_q;
        work_d      = work_q;
        act_d       = act_q;
        left_d      = left_q;
        right_d     = right_q;
        audio_out_d = audio_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        mac_clr_c   = 1'b0;
        mac_en_c    = 1'b0;

        edge_c       = AUD_DACLRCK & ~lrck_q;
        idx_c        = circ_idx(newest_q, k_q);
        mac_coef_c   = act_q[k_q];
        mac_sample_c = (state_q == MAC_R) ? buf_r_q[idx_c] : buf_l_q[idx_c];

        // working bank accepts writes in every state; act_d below sees a same-cycle write
        if (coef_we && (coef_addr < AW'(TAPS))) begin
            work_d[coef_addr] = coef_data;
        end

        unique case (state_q)
            IDLE: begin
                if (edge_c) begin
                    buf_l_d[wr_ptr_q] = audioIn[31:16];
                    buf_r_d[wr_ptr_q] = audioIn[15:0];
                    act_d             = work_d;
                    mac_clr_c         = 1'b1;
                    k_d               = '0;
                    newest_d          = wr_ptr_q;
                    wr_ptr_d          = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + AW'(1);
                    state_d           = MAC_L;
                end
            end
            MAC_L: begin
                mac_en_c = 1'b1;
                if (k_q == AW'(TAPS - 1)) begin
                    left_d    = mac_sat_c;
                    mac_clr_c = 1'b1;
                    k_d       = '0;
                    state_d   = MAC_R;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            MAC_R: begin
                mac_en_c = 1'b1;
                if (k_q == AW'(TAPS - 1)) begin
                    right_d   = mac_sat_c;
                    mac_clr_c = 1'b1;
                    k_d       = '0;
                    state_d   = OUT;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            OUT: begin
                audio_out_d = {left_q, right_q};
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a frame edge during computation is dropped and flagged
        if (edge_c && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lrck_q      <= 1'b0;
            k_q         <= '0;
            newest_q    <= '0;
            wr_ptr_q    <= '0;
            left_q      <= '0;
            right_q     <= '0;
            audio_out_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                buf_l_q[i] <= '0;
                buf_r_q[i] <= '0;
                work_q[i]  <= '0;
                act_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            lrck_q      <= AUD_DACLRCK;
            k_q         <= k_d;
            newest_q    <= newest_d;
            wr_ptr_q    <= wr_ptr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            audio_out_q <= audio_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < int'(TAPS); i++) begin
                buf_l_q[i] <= buf_l_d[i];
                buf_r_q[i] <= buf_r_d[i];
                work_q[i]  <= work_d[i];
                act_q[i]   <= act_d[i];
            end
        end
    end

    assign audioOut  = audio_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and randomized bench for fir_mac_sequencer against a convolution-level reference model.
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        AUD_DACLRCK;
    logic [31:0] audioIn;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic [31:0] audioOut;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .AUD_DACLRCK (AUD_DACLRCK),
        .audioIn     (audioIn),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .audioOut    (audioOut),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // reference model: working bank, bank snapshot for the current frame, newest-first histories
    int work_m [9];
    int act_m  [9];
    int hl [$];
    int hr [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [15:0] sat_model(input longint acc);
        longint y;
        y = acc >>> 15;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return 16'(y);
    endfunction

    function automatic logic [31:0] expect_out();
        longint al;
        longint ar;
        al = 0;
        ar = 0;
        for (int j = 0; j < hl.size(); j++) begin
            al += longint'(act_m[j]) * longint'(hl[j]);
            ar += longint'(act_m[j]) * longint'(hr[j]);
        end
        return {sat_model(al), sat_model(ar)};
    endfunction

    task automatic model_write(input int a, input int d);
        if (a < 9) work_m[a] = s16(16'(d));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) work_m[i] = 0;
        hl.delete();
        hr.delete();
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 16'(d);
        tick();
        coef_we = 1'b0;
        model_write(a, d);
    endtask

    // one frame edge; optional coefficient write at cycle E+wr_at (0 = same cycle as the edge)
    // and optional extra frame edge at cycle E+ovr_at
    task automatic do_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                            input int wr_at, input int wr_a, input int wr_d, input int ovr_at);
        logic [31:0] exp;
        logic [31:0] got;
        int nvalid;
        int lat;
        audioIn     = {l, r};
        AUD_DACLRCK = 1'b1;
        if (wr_at == 0) begin
            coef_we   = 1'b1;
            coef_addr = 4'(wr_a);
            coef_data = 16'(wr_d);
            model_write(wr_a, wr_d);
        end
        act_m = work_m;
        hl.push_front(s16(l));
        hr.push_front(s16(r));
        if (hl.size() > 9) void'(hl.pop_back());
        if (hr.size() > 9) void'(hr.pop_back());
        exp = expect_out();
        tick();
        AUD_DACLRCK = 1'b0;
        coef_we     = 1'b0;
        check({tag, " busy@E+1"}, 32'(busy), 32'd1);
        nvalid = 0;
        lat    = 0;
        got    = '0;
        for (int c = 1; c <= 24; c++) begin
            if (c == wr_at) begin
                coef_we   = 1'b1;
                coef_addr = 4'(wr_a);
                coef_data = 16'(wr_d);
            end else begin
                coef_we = 1'b0;
            end
            AUD_DACLRCK = (c == ovr_at);
            if (c == 19) check({tag, " busy@E+19"}, 32'(busy), 32'd1);
            if (out_valid) begin
                nvalid++;
                if (lat == 0) lat = c;
                got = audioOut;
            end
            tick();
        end
        coef_we     = 1'b0;
        AUD_DACLRCK = 1'b0;
        if (wr_at > 0) model_write(wr_a, wr_d);
        check({tag, " valid_count"}, 32'(nvalid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'd20);
        check({tag, " audioOut"}, got, exp);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int nvalid;
        rst         = 1'b0;
        AUD_DACLRCK = 1'b0;
        audioIn     = '0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_data   = '0;

        // reset state
        do_reset();
        check("reset audioOut", audioOut, 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);

        // impulse through tap 0
        write_coef(0, 16384);
        do_frame("impulse", 16'd1000, 16'hF830, -1, 0, 0, -1);
        check("impulse const", audioOut, {16'd500, 16'hFC18});

        // pure delay on tap 8 with circular-pointer wrap
        do_reset();
        write_coef(8, 16384);
        for (int n = 1; n <= 12; n++) begin
            do_frame($sformatf("delay%0d", n), 16'(100 * n), 16'(7 * n), -1, 0, 0, -1);
        end
        check("delay frame12 L", 32'(audioOut[31:16]), 32'd200);

        // saturation at both rails
        do_reset();
        for (int i = 0; i < 9; i++) write_coef(i, 32767);
        for (int n = 0; n < 9; n++) do_frame("sat", 16'h7FFF, 16'h8000, -1, 0, 0, -1);
        check("sat const", audioOut, {16'h7FFF, 16'h8000});

        // coefficient timing: mid-frame write, invalid address, same-cycle write
        do_reset();
        write_coef(0, 16384);
        do_frame("coef_mid", 16'd1000, 16'd0, 5, 0, 8192, -1);
        check("coef_mid const", 32'(audioOut[31:16]), 32'd500);
        do_frame("coef_next", 16'd1000, 16'd0, -1, 0, 0, -1);
        check("coef_next const", 32'(audioOut[31:16]), 32'd250);
        write_coef(12, 16'h7000);
        do_frame("coef_bad_addr", 16'd1000, 16'd0, -1, 0, 0, -1);
        check("coef_bad_addr const", 32'(audioOut[31:16]), 32'd250);
        do_frame("coef_same_cycle", 16'd1000, 16'd0, 0, 0, 4096, -1);
        check("coef_same_cycle const", 32'(audioOut[31:16]), 32'd125);

        // overrun: second edge 9 cycles later is dropped; later frames must not see it
        for (int i = 0; i < 9; i++) write_coef(i, 3000 + 500 * i);
        do_frame("overrun", 16'd1200, 16'hF000, -1, 0, 0, 9);
        check("overrun set", 32'(overrun), 32'd1);
        do_frame("post_overrun", 16'd300, 16'd400, -1, 0, 0, -1);
        check("overrun sticky", 32'(overrun), 32'd1);

        // randomized frames with random coefficient traffic
        for (int n = 0; n < 16; n++) begin
            int wa;
            int wd;
            int wat;
            if ($urandom_range(0, 1) == 1) write_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
            wa  = int'($urandom_range(0, 15));
            wd  = int'($urandom_range(0, 65535));
            wat = int'($urandom_range(0, 20)) - 1;
            do_frame($sformatf("rand%0d", n), 16'($urandom), 16'($urandom), wat, wa, wd, -1);
        end

        // reset in the middle of a frame
        audioIn     = {16'd5000, 16'd6000};
        AUD_DACLRCK = 1'b1;
        tick();
        AUD_DACLRCK = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        do_reset();
        nvalid = 0;
        for (int c = 0; c < 24; c++) begin
            if (out_valid) nvalid++;
            tick();
        end
        check("midreset valid_count", 32'(nvalid), 32'd0);
        check("midreset audioOut", audioOut, 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset overrun", 32'(overrun), 32'd0);
        do_frame("after_reset", 16'd20000, 16'h9000, -1, 0, 0, -1);
        check("after_reset const", audioOut, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
